lfsr_rand_gen: RTL and testbench

Parametrised pseudo-random generator that supersedes the fixed 3-bit shift-register generator. It is a maximal-length LFSR of configurable width with run-time Fibonacci/Galois mode, seed load with zero-lock-up protection, a valid/ready output handshake with stall, and a period-wrap pulse. It feeds test-pattern and dither consumers that may back-pressure.

---
 rtl/lfsr_pkg.sv | 65 ++++++
 rtl/lfsr_rand_gen_if.sv | 25 ++
 rtl/lfsr_step.sv | 25 ++
 rtl/lfsr_rand_gen.sv | 92 +++++++++
 tb/tb_lfsr_rand_gen.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and maximal-length polynomial tables for the LFSR generator.
package lfsr_pkg;

  localparam int unsigned LFSR_MIN_WIDTH = 3;
  localparam int unsigned LFSR_MAX_WIDTH = 16;

  // Step flavour: shift-register feedback or internal XOR feedback.
  typedef enum logic {
    FIBONACCI = 1'b0,
    GALOIS    = 1'b1
  } lfsr_mode_e;

  // Control state: LOAD tracks start, RUN steps on handshake.
  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } lfsr_fsm_e;

  // Fibonacci feedback taps (bit k = stage k+1), left-shift, feedback into LSB.
  function automatic logic [LFSR_MAX_WIDTH-1:0] tap_mask(input int unsigned width);
    logic [LFSR_MAX_WIDTH-1:0] m;
    case (width)
      3:       m = 16'h0006;
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  // Galois polynomial: low-order coefficients of a primitive x^W + ... + 1.
  function automatic logic [LFSR_MAX_WIDTH-1:0] galois_poly(input int unsigned width);
    logic [LFSR_MAX_WIDTH-1:0] p;
    case (width)
      3:       p = 16'h0005;
      4:       p = 16'h0009;
      5:       p = 16'h0009;
      6:       p = 16'h0021;
      7:       p = 16'h0041;
      8:       p = 16'h0071;
      9:       p = 16'h0021;
      10:      p = 16'h0081;
      11:      p = 16'h0201;
      12:      p = 16'h0053;
      13:      p = 16'h001B;
      14:      p = 16'h002B;
      15:      p = 16'h4001;
      16:      p = 16'hA011;
      default: p = 16'h0000;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/lfsr_rand_gen_if.sv
// Output sample handshake between the generator and its consumer.
interface lfsr_rand_gen_if #(
  parameter int unsigned WIDTH = 3
);

  logic [WIDTH-1:0] random;
  logic             out_valid;
  logic             out_ready;
  logic             period_wrap;

  modport master (
    output random,
    output out_valid,
    output period_wrap,
    input  out_ready
  );

  modport slave (
    input  random,
    input  out_valid,
    input  period_wrap,
    output out_ready
  );

endinterface

// File: rtl/lfsr_step.sv
// Combinational one-step next-state function for Fibonacci or Galois LFSR.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] state,
  input  lfsr_mode_e       mode,
  output logic [WIDTH-1:0] next
);

  localparam logic [WIDTH-1:0] TAP_MASK    = WIDTH'(tap_mask(WIDTH));
  localparam logic [WIDTH-1:0] GALOIS_POLY = WIDTH'(galois_poly(WIDTH));

  // Select the step flavour; both shift toward the MSB.
  always_comb begin
    next = '0;
    if (mode == GALOIS) begin
      next = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? GALOIS_POLY : '0);
    end else begin
      next = {state[WIDTH-2:0], ^(state & TAP_MASK)};
    end
  end

endmodule

// File: rtl/lfsr_rand_gen.sv
// Maximal-length LFSR random source with seed load, valid/ready stall and wrap pulse.
module lfsr_rand_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH        = 3,
  parameter int unsigned DEFAULT_SEED = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sel,
  input  logic               mode,
  input  logic [WIDTH-1:0]   start,
  output logic               seed_fixed,
  lfsr_rand_gen_if.master    bus
);

  localparam logic [WIDTH-1:0] RST_SEED = WIDTH'(DEFAULT_SEED);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  if ((WIDTH < LFSR_MIN_WIDTH) || (WIDTH > LFSR_MAX_WIDTH)) begin : g_bad_width
    $error("lfsr_rand_gen: WIDTH out of the 3..16 table range");
  end

  lfsr_fsm_e        r_fsm;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_seed;
  lfsr_mode_e       r_mode;
  logic [WIDTH-1:0] r_step_cnt;
  logic             r_valid;
  logic             r_wrap;
  logic             r_seed_fixed;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_seed;
  logic             w_start_zero;
  logic             w_fire;

  lfsr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .state (r_state),
    .mode  (r_mode),
    .next  (w_next)
  );

  // Zero seed would lock the register up, so substitute 1.
  always_comb begin
    w_start_zero = (start == '0);
    w_load_seed  = w_start_zero ? ONE : start;
    w_fire       = r_valid & bus.out_ready;
  end

  // LOAD/RUN control, state and seed registers, counter and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm        <= ST_LOAD;
      r_state      <= RST_SEED;
      r_seed       <= RST_SEED;
      r_mode       <= FIBONACCI;
      r_step_cnt   <= '0;
      r_valid      <= 1'b0;
      r_wrap       <= 1'b0;
      r_seed_fixed <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (!sel || (r_fsm == ST_LOAD)) begin
        // Loading on every LOAD edge and on the RUN->LOAD edge; pending step dropped.
        r_state      <= w_load_seed;
        r_seed       <= w_load_seed;
        r_seed_fixed <= w_start_zero;
        r_mode       <= lfsr_mode_e'(mode);
        r_step_cnt   <= '0;
        r_valid      <= sel;
        r_fsm        <= sel ? ST_RUN : ST_LOAD;
      end else if (w_fire) begin
        r_state <= w_next;
        if (w_next == r_seed) begin
          r_wrap     <= 1'b1;
          r_step_cnt <= '0;
        end else begin
          r_step_cnt <= r_step_cnt + ONE;
        end
      end
    end
  end

  assign bus.random      = r_state;
  assign bus.out_valid   = r_valid;
  assign bus.period_wrap = r_wrap;
  assign seed_fixed      = r_seed_fixed;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed self-checking bench for lfsr_rand_gen at WIDTH=3 and WIDTH=8.
module tb_lfsr_rand_gen;

  localparam int unsigned W3    = 3;
  localparam int unsigned W8    = 8;
  localparam int unsigned SEED3 = 5;
  localparam int unsigned SEED8 = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          sel3, mode3, sel8, mode8;
  logic [W3-1:0] start3;
  logic [W8-1:0] start8;
  logic          fixed3, fixed8;

  int errors = 0;
  int checks = 0;

  lfsr_rand_gen_if #(.WIDTH(W3)) bus3 ();
  lfsr_rand_gen_if #(.WIDTH(W8)) bus8 ();

  lfsr_rand_gen #(.WIDTH(W3), .DEFAULT_SEED(SEED3)) u3 (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel3),
    .mode       (mode3),
    .start      (start3),
    .seed_fixed (fixed3),
    .bus        (bus3)
  );

  lfsr_rand_gen #(.WIDTH(W8), .DEFAULT_SEED(SEED8)) u8 (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel8),
    .mode       (mode8),
    .start      (start8),
    .seed_fixed (fixed8),
    .bus        (bus8)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Put the 3-bit DUT into RUN with a given seed and mode; first sample = seed.
  task automatic start_run3(input logic [W3-1:0] seed, input logic m);
    sel3 = 1'b0; mode3 = m; start3 = seed; bus3.out_ready = 1'b1;
    tick();
    sel3 = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sel3 = 1'b0; mode3 = 1'b0; start3 = 3'd1; bus3.out_ready = 1'b0;
    sel8 = 1'b0; mode8 = 1'b0; start8 = 8'h01; bus8.out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (bus3.random !== 3'd5) begin
      errors++; $display("FAIL reset_random3 got=%0d exp=5", bus3.random);
    end
    checks++;
    if (bus8.random !== 8'h01) begin
      errors++; $display("FAIL reset_random8 got=%0h exp=01", bus8.random);
    end
    checks++;
    if ({bus3.out_valid, bus3.period_wrap, fixed3} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b exp=000", {bus3.out_valid, bus3.period_wrap, fixed3});
    end
    reset = 1'b0;
  endtask

  task automatic test_fibonacci();
    logic [W3-1:0] exp_seq [8] = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4, 3'd1};
    int wraps = 0;
    start_run3(3'd1, 1'b0);
    checks++;
    if (bus3.out_valid !== 1'b1) begin
      errors++; $display("FAIL fib_valid got=%b exp=1", bus3.out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      checks++;
      if (bus3.random !== exp_seq[i]) begin
        errors++; $display("FAIL fib_seq[%0d] got=%0d exp=%0d", i, bus3.random, exp_seq[i]);
      end
      if (bus3.period_wrap === 1'b1) begin
        wraps++;
        checks++;
        if (i != 7) begin
          errors++; $display("FAIL fib_wrap_pos got=step%0d exp=step7", i);
        end
      end
    end
    checks++;
    if (wraps != 1) begin
      errors++; $display("FAIL fib_wrap_count got=%0d exp=1", wraps);
    end
  endtask

  task automatic test_galois();
    logic [W3-1:0] exp_seq [8] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd7, 3'd3, 3'd6, 3'd1};
    int wraps = 0;
    start_run3(3'd1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      checks++;
      if (bus3.random !== exp_seq[i]) begin
        errors++; $display("FAIL gal_seq[%0d] got=%0d exp=%0d", i, bus3.random, exp_seq[i]);
      end
      if (bus3.period_wrap === 1'b1) wraps++;
    end
    checks++;
    if (wraps != 1 || bus3.period_wrap !== 1'b1) begin
      errors++; $display("FAIL gal_wrap got=%0d/%b exp=1/1", wraps, bus3.period_wrap);
    end
  endtask

  task automatic test_mode_toggle();
    logic [W3-1:0] exp_seq [8] = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4, 3'd1};
    start_run3(3'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      mode3 = ~mode3;
      checks++;
      if (bus3.random !== exp_seq[i]) begin
        errors++; $display("FAIL mode_toggle[%0d] got=%0d exp=%0d", i, bus3.random, exp_seq[i]);
      end
    end
    mode3 = 1'b0;
  endtask

  task automatic test_stall();
    logic [W3-1:0] exp_after [2] = '{3'd6, 3'd4};
    start_run3(3'd3, 1'b0);
    tick();
    checks++;
    if (bus3.random !== 3'd7) begin
      errors++; $display("FAIL stall_pre got=%0d exp=7", bus3.random);
    end
    bus3.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus3.random !== 3'd7 || bus3.out_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d] got=%0d/%b exp=7/1", i, bus3.random, bus3.out_valid);
      end
    end
    bus3.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus3.random !== exp_after[i]) begin
        errors++; $display("FAIL stall_resume[%0d] got=%0d exp=%0d", i, bus3.random, exp_after[i]);
      end
    end
  endtask

  task automatic test_zero_seed();
    int n = 0;
    bit done = 0;
    bit zero_seen = 0;
    sel3 = 1'b0; mode3 = 1'b0; start3 = 3'd0; bus3.out_ready = 1'b1;
    tick();
    checks++;
    if (bus3.random !== 3'd1 || fixed3 !== 1'b1 || bus3.out_valid !== 1'b0) begin
      errors++; $display("FAIL zero_load got=%0d/%b/%b exp=1/1/0", bus3.random, fixed3, bus3.out_valid);
    end
    sel3 = 1'b1;
    tick();
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      n++;
      if (bus3.random === 3'd0) zero_seen = 1;
      if (bus3.period_wrap === 1'b1) done = 1;
    end
    checks++;
    if (!done || n != 7 || zero_seen) begin
      errors++; $display("FAIL zero_period got=%0d done=%0d zero=%0d exp=7 1 0", n, done, zero_seen);
    end
  endtask

  task automatic test_reset_mid_run();
    // Still running from the zero-seed case with seed_fixed set.
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (bus3.random !== 3'd5 || bus3.out_valid !== 1'b0 || fixed3 !== 1'b0 || bus3.period_wrap !== 1'b0) begin
      errors++; $display("FAIL reset_mid_run got=%0d/%b/%b/%b exp=5/0/0/0",
                         bus3.random, bus3.out_valid, fixed3, bus3.period_wrap);
    end
    reset = 1'b0;
    sel3 = 1'b0;
    start3 = 3'd2;
    tick();
    checks++;
    if (bus3.random !== 3'd2 || bus3.out_valid !== 1'b0) begin
      errors++; $display("FAIL reload_after_reset got=%0d/%b exp=2/0", bus3.random, bus3.out_valid);
    end
  endtask

  task automatic test_load_wins();
    start_run3(3'd1, 1'b0);
    tick();
    sel3 = 1'b0;
    start3 = 3'd6;
    tick();
    checks++;
    if (bus3.random !== 3'd6 || bus3.out_valid !== 1'b0 || bus3.period_wrap !== 1'b0) begin
      errors++; $display("FAIL load_wins got=%0d/%b/%b exp=6/0/0", bus3.random, bus3.out_valid, bus3.period_wrap);
    end
  endtask

  task automatic test_width8();
    for (int m = 0; m < 2; m++) begin
      int n = 0;
      int wraps = 0;
      bit zero_seen = 0;
      sel8 = 1'b0; mode8 = m[0]; start8 = 8'h01; bus8.out_ready = 1'b1;
      tick();
      sel8 = 1'b1;
      tick();
      for (int i = 0; i < 600 && wraps < 2; i++) begin
        tick();
        n++;
        if (bus8.random === 8'h00) zero_seen = 1;
        if (bus8.period_wrap === 1'b1) begin
          checks++;
          if (n != 255) begin
            errors++; $display("FAIL w8_period mode=%0d got=%0d exp=255", m, n);
          end
          n = 0;
          wraps++;
        end
      end
      checks++;
      if (wraps != 2 || zero_seen) begin
        errors++; $display("FAIL w8_run mode=%0d wraps=%0d zero=%0d exp=2 0", m, wraps, zero_seen);
      end
      sel8 = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fibonacci();
    test_galois();
    test_mode_toggle();
    test_stall();
    test_load_wins();
    test_zero_seed();
    test_reset_mid_run();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
